// File: rtl/result_pipe.sv
// EX/MEM and MEM/WB pipeline registers with a two-state data-memory access FSM.
// Handles load extension, store lane steering, misalignment drops and access timeouts.
module result_pipe #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mask,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  exmem_rd,
  output logic        exmem_reg_write,
  output logic        exmem_is_load,
  output logic [31:0] exmem_alu_result,
  output logic [4:0]  memwb_rd,
  output logic        memwb_reg_write,
  output logic [31:0] memwb_wb_value,
  output logic        misalign_err,
  output logic        mem_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  // EX/MEM register
  logic        em_valid;
  logic [4:0]  em_rd;
  logic        em_reg_write;
  logic        em_mem_read;
  logic        em_mem_write;
  logic [2:0]  em_funct3;
  logic [31:0] em_alu;
  logic [31:0] em_store;

  // MEM/WB register
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_value;

  logic        is_mem, is_byte, is_half, misaligned;
  logic        mem_op, mem_ok, timeout_hit, ack, drain;
  logic [1:0]  byte_off;
  logic        wb_we_nx;
  logic [31:0] wb_value_nx;
  logic [31:0] load_value;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_mask;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign is_mem   = em_mem_read | em_mem_write;
  assign byte_off = em_alu[1:0];
  assign is_byte  = (em_funct3[1:0] == 2'b00);
  assign is_half  = (em_funct3[1:0] == 2'b01);

  // Undefined size codes fall through to word accesses, so they need word alignment.
  assign misaligned = is_half ? byte_off[0] : (!is_byte && (byte_off != 2'b00));

  assign mem_op      = em_valid && is_mem;
  assign mem_ok      = mem_op && !misaligned;
  assign timeout_hit = (state == S_WAIT) && (cnt == CNT_LAST);

  // The request drops in the final timeout cycle, which also masks any late ack there.
  assign dmem_req = mem_ok && !timeout_hit;
  assign ack      = dmem_ack && dmem_req;

  assign misalign_err = (state == S_IDLE) && mem_op && misaligned;
  assign mem_timeout  = timeout_hit;

  assign ex_ready = !((state == S_WAIT) && !ack) && !((state == S_IDLE) && mem_op);

  assign drain = em_valid && (!is_mem || misaligned || ack || timeout_hit);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sel_byte   = dmem_rdata[7:0];
    sel_half   = byte_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_value = dmem_rdata;
    lane_wdata = em_store;
    lane_mask  = 4'b1111;

    case (byte_off)
      2'd1:    sel_byte = dmem_rdata[15:8];
      2'd2:    sel_byte = dmem_rdata[23:16];
      2'd3:    sel_byte = dmem_rdata[31:24];
      default: sel_byte = dmem_rdata[7:0];
    endcase

    if (is_byte) begin
      load_value = {{24{!em_funct3[2] && sel_byte[7]}}, sel_byte};
      lane_wdata = {4{em_store[7:0]}};
      lane_mask  = 4'b0001 << byte_off;
    end else if (is_half) begin
      load_value = {{16{!em_funct3[2] && sel_half[15]}}, sel_half};
      lane_wdata = {2{em_store[15:0]}};
      lane_mask  = byte_off[1] ? 4'b1100 : 4'b0011;
    end
  end

  assign dmem_we    = dmem_req && !em_mem_read;
  assign dmem_addr  = dmem_req ? {em_alu[31:2], 2'b00} : 32'h0;
  assign dmem_wdata = dmem_req ? lane_wdata : 32'h0;
  assign dmem_mask  = dmem_req ? lane_mask : 4'h0;

  // Stores, dropped accesses and x0 targets all retire as MEM/WB bubbles.
  assign wb_we_nx    = drain && em_reg_write && (em_rd != 5'd0) &&
                       (is_mem ? (em_mem_read && ack) : 1'b1);
  assign wb_value_nx = is_mem ? load_value : em_alu;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (mem_ok && !ack) begin
          state_nx = S_WAIT;
          cnt_nx   = '0;
        end
      end
      S_WAIT: begin
        if (ack || timeout_hit) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // NOTE: datapath fields are reset too, so every output reads zero straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      em_valid     <= 1'b0;
      em_rd        <= '0;
      em_reg_write <= 1'b0;
      em_mem_read  <= 1'b0;
      em_mem_write <= 1'b0;
      em_funct3    <= '0;
      em_alu       <= '0;
      em_store     <= '0;
    end else if (ex_valid && ex_ready) begin
      em_valid     <= 1'b1;
      em_rd        <= ex_rd;
      em_reg_write <= ex_reg_write;
      em_mem_read  <= ex_mem_read;
      em_mem_write <= ex_mem_write;
      em_funct3    <= ex_funct3;
      em_alu       <= ex_alu_result;
      em_store     <= ex_store_data;
    end else if (drain) begin
      em_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_value <= '0;
    end else begin
      wb_valid <= wb_we_nx;
      wb_rd    <= wb_we_nx ? em_rd : 5'd0;
      wb_value <= wb_we_nx ? wb_value_nx : 32'h0;
    end
  end

  assign exmem_rd         = em_rd;
  assign exmem_reg_write  = em_valid && em_reg_write && !em_mem_read && (em_rd != 5'd0);
  assign exmem_is_load    = em_valid && em_mem_read && (em_rd != 5'd0);
  assign exmem_alu_result = em_alu;
  assign memwb_rd         = wb_rd;
  assign memwb_reg_write  = wb_valid;
  assign memwb_wb_value   = wb_value;

endmodule

// File: tb/tb_result_pipe.sv
// Directed bench for result_pipe: single-op vector table plus hand-written
// multi-cycle sequences for wait states, timeout and reset mid-access.
module tb_result_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_result, ex_store_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_mask;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, exmem_is_load, memwb_reg_write;
  logic [31:0] exmem_alu_result, memwb_wb_value;
  logic        misalign_err, mem_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  result_pipe #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_mask(dmem_mask), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_is_load(exmem_is_load),
    .exmem_alu_result(exmem_alu_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_wb_value(memwb_wb_value),
    .misalign_err(misalign_err), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
    logic        exp_misalign;
    logic        exp_fwd;
    logic        exp_is_load;
    logic        exp_wb;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic mr, logic mw, logic [2:0] f3,
                              logic [4:0] rd, logic rw, logic [31:0] alu,
                              logic [31:0] sd, logic [31:0] rdata, logic req,
                              logic [31:0] addr, logic [3:0] mask, logic [31:0] wdata,
                              logic mis, logic fwd, logic isl, logic wb,
                              logic [31:0] val);
    vec_t v;
    v.name = name; v.mem_read = mr; v.mem_write = mw; v.funct3 = f3;
    v.rd = rd; v.reg_write = rw; v.alu = alu; v.sdata = sd; v.rdata = rdata;
    v.exp_req = req; v.exp_addr = addr; v.exp_mask = mask; v.exp_wdata = wdata;
    v.exp_misalign = mis; v.exp_fwd = fwd; v.exp_is_load = isl;
    v.exp_wb = wb; v.exp_val = val;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic mr, input logic mw, input logic [2:0] f3,
                          input logic [4:0] rd, input logic rw,
                          input logic [31:0] alu, input logic [31:0] sd);
    ex_valid = 1'b1; ex_mem_read = mr; ex_mem_write = mw; ex_funct3 = f3;
    ex_rd = rd; ex_reg_write = rw; ex_alu_result = alu; ex_store_data = sd;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".ex_ready"}, ex_ready, 1);
    check({tag, ".dmem_req"}, dmem_req, 0);
    check({tag, ".dmem_we"}, dmem_we, 0);
    check({tag, ".dmem_addr"}, dmem_addr, 0);
    check({tag, ".dmem_wdata"}, dmem_wdata, 0);
    check({tag, ".dmem_mask"}, dmem_mask, 0);
    check({tag, ".exmem_rd"}, exmem_rd, 0);
    check({tag, ".exmem_reg_write"}, exmem_reg_write, 0);
    check({tag, ".exmem_is_load"}, exmem_is_load, 0);
    check({tag, ".exmem_alu_result"}, exmem_alu_result, 0);
    check({tag, ".memwb_rd"}, memwb_rd, 0);
    check({tag, ".memwb_reg_write"}, memwb_reg_write, 0);
    check({tag, ".memwb_wb_value"}, memwb_wb_value, 0);
    check({tag, ".misalign_err"}, misalign_err, 0);
    check({tag, ".mem_timeout"}, mem_timeout, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish within 20000 cycles");
    $fatal(1);
  end

  initial begin
    int req_cnt, to_cnt, wb_cnt;

    vecs.push_back(mk("add_x5",   0,0,3'b000, 5,1,32'h10,  0,0,            0,0,0,0,                 0,1,0,1,32'h10));
    vecs.push_back(mk("alu_x0",   0,0,3'b000, 0,1,32'h1234,0,0,            0,0,0,0,                 0,0,0,0,0));
    vecs.push_back(mk("lw_x7",    1,0,3'b010, 7,1,32'h100, 0,32'hDEADBEEF, 1,32'h100,4'hF,0,        0,0,1,1,32'hDEADBEEF));
    vecs.push_back(mk("lbu_x8",   1,0,3'b100, 8,1,32'h101, 0,32'h12348056, 1,32'h100,4'h2,0,        0,0,1,1,32'h00000080));
    vecs.push_back(mk("lh_x9",    1,0,3'b001, 9,1,32'h102, 0,32'h80017FFF, 1,32'h100,4'hC,0,        0,0,1,1,32'hFFFF8001));
    vecs.push_back(mk("lhu_x10",  1,0,3'b101,10,1,32'h100, 0,32'h8001F00F, 1,32'h100,4'h3,0,        0,0,1,1,32'h0000F00F));
    vecs.push_back(mk("lb_x11",   1,0,3'b000,11,1,32'h100, 0,32'h0000007F, 1,32'h100,4'h1,0,        0,0,1,1,32'h0000007F));
    vecs.push_back(mk("ld_f3_011",1,0,3'b011,12,1,32'h8,   0,32'hCAFEF00D, 1,32'h8,  4'hF,0,        0,0,1,1,32'hCAFEF00D));
    vecs.push_back(mk("lb_x0",    1,0,3'b000, 0,1,32'h100, 0,32'h00000055, 1,32'h100,4'h1,0,        0,0,0,0,0));
    vecs.push_back(mk("sb_lane1", 0,1,3'b000, 0,0,32'h301, 32'h000000A5,0, 1,32'h300,4'b0010,32'hA5A5A5A5, 0,0,0,0,0));
    vecs.push_back(mk("sb_lane3", 0,1,3'b000, 0,0,32'h303, 32'h12345677,0, 1,32'h300,4'b1000,32'h77777777, 0,0,0,0,0));
    vecs.push_back(mk("sh_hi",    0,1,3'b001, 0,0,32'h202, 32'h0000ABCD,0, 1,32'h200,4'b1100,32'hABCDABCD, 0,0,0,0,0));
    vecs.push_back(mk("sw",       0,1,3'b010, 0,0,32'h404, 32'h11223344,0, 1,32'h404,4'b1111,32'h11223344, 0,0,0,0,0));
    vecs.push_back(mk("lw_misal", 1,0,3'b010,13,1,32'h6,   0,32'hFFFFFFFF, 0,0,0,0,                 1,0,1,0,0));
    vecs.push_back(mk("sh_misal", 0,1,3'b001, 0,0,32'h203, 32'h1,0,        0,0,0,0,                 1,0,0,0,0));
    vecs.push_back(mk("lh_misal", 1,0,3'b001,14,1,32'h101, 0,32'hFFFFFFFF, 0,0,0,0,                 1,0,1,0,0));

    rst_n = 1'b0; ex_valid = 1'b0; ex_rd = '0; ex_reg_write = 1'b0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = '0;
    ex_alu_result = '0; ex_store_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_quiet("reset");
    tick();

    // Table: issue one op, complete it with an immediate ack, observe writeback.
    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive_ex(v.mem_read, v.mem_write, v.funct3, v.rd, v.reg_write, v.alu, v.sdata);
      @(negedge clk);
      check({v.name, ".accept"}, ex_ready, 1);
      tick();
      ex_valid = 1'b0; dmem_ack = 1'b1; dmem_rdata = v.rdata;
      @(negedge clk);
      check({v.name, ".ex_ready"}, ex_ready, !(v.mem_read || v.mem_write));
      check({v.name, ".dmem_req"}, dmem_req, v.exp_req);
      check({v.name, ".misalign_err"}, misalign_err, v.exp_misalign);
      check({v.name, ".exmem_rd"}, exmem_rd, v.rd);
      check({v.name, ".exmem_reg_write"}, exmem_reg_write, v.exp_fwd);
      check({v.name, ".exmem_is_load"}, exmem_is_load, v.exp_is_load);
      if (v.exp_fwd) check({v.name, ".exmem_alu_result"}, exmem_alu_result, v.alu);
      if (v.exp_req) begin
        check({v.name, ".dmem_addr"}, dmem_addr, v.exp_addr);
        check({v.name, ".dmem_we"}, dmem_we, v.mem_write);
        if (v.mem_write) begin
          check({v.name, ".dmem_mask"}, dmem_mask, v.exp_mask);
          check({v.name, ".dmem_wdata"}, dmem_wdata, v.exp_wdata);
        end
      end
      tick();
      dmem_ack = 1'b0;
      @(negedge clk);
      check({v.name, ".memwb_reg_write"}, memwb_reg_write, v.exp_wb);
      check({v.name, ".misalign_after"}, misalign_err, 0);
      check({v.name, ".ready_after"}, ex_ready, 1);
      if (v.exp_wb) begin
        check({v.name, ".memwb_rd"}, memwb_rd, v.rd);
        check({v.name, ".memwb_wb_value"}, memwb_wb_value, v.exp_val);
      end
      tick();
    end

    // LB x6 @0x103 acked after three stalled cycles, with an ADD accepted on the ack cycle.
    drive_ex(1, 0, 3'b000, 6, 1, 32'h103, 0);
    tick();
    ex_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("lb_wait%0d.ex_ready", c), ex_ready, 0);
      check($sformatf("lb_wait%0d.dmem_req", c), dmem_req, 1);
      check($sformatf("lb_wait%0d.dmem_addr", c), dmem_addr, 32'h100);
      check($sformatf("lb_wait%0d.exmem_is_load", c), exmem_is_load, 1);
      check($sformatf("lb_wait%0d.exmem_reg_write", c), exmem_reg_write, 0);
      check($sformatf("lb_wait%0d.memwb_reg_write", c), memwb_reg_write, 0);
      tick();
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h80FFFFFF;
    drive_ex(0, 0, 3'b000, 3, 1, 32'h55, 0);
    @(negedge clk);
    check("lb_ack.ex_ready", ex_ready, 1);
    check("lb_ack.dmem_req", dmem_req, 1);
    tick();
    ex_valid = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    check("lb_wb.memwb_reg_write", memwb_reg_write, 1);
    check("lb_wb.memwb_rd", memwb_rd, 6);
    check("lb_wb.memwb_wb_value", memwb_wb_value, 32'hFFFFFF80);
    check("lb_wb.exmem_rd", exmem_rd, 3);
    check("lb_wb.exmem_reg_write", exmem_reg_write, 1);
    tick();
    @(negedge clk);
    check("add_wb.memwb_rd", memwb_rd, 3);
    check("add_wb.memwb_wb_value", memwb_wb_value, 32'h55);
    tick();
    @(negedge clk);
    check("add_wb.once", memwb_reg_write, 0);
    tick();

    // LW with no ack: four request cycles, one timeout pulse, no writeback.
    drive_ex(1, 0, 3'b010, 4, 1, 32'h10, 0);
    tick();
    ex_valid = 1'b0;
    req_cnt = 0; to_cnt = 0; wb_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (dmem_req) req_cnt++;
      if (mem_timeout) to_cnt++;
      if (memwb_reg_write) wb_cnt++;
      tick();
    end
    @(negedge clk);
    check("timeout.req_cycles", req_cnt, 4);
    check("timeout.pulses", to_cnt, 1);
    check("timeout.writebacks", wb_cnt, 0);
    check("timeout.ex_ready", ex_ready, 1);
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    @(negedge clk);
    check("late_ack.dmem_req", dmem_req, 0);
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    check("late_ack.memwb_reg_write", memwb_reg_write, 0);
    tick();

    // Reset in the second WAIT cycle, then a stray ack.
    drive_ex(1, 0, 3'b010, 9, 1, 32'h20, 0);
    tick();
    ex_valid = 1'b0;
    @(negedge clk);
    check("rst_wait.req_idle", dmem_req, 1);
    tick();
    @(negedge clk);
    check("rst_wait.req_wait1", dmem_req, 1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    check_quiet("rst_wait.after");
    tick();
    @(negedge clk);
    check("rst_wait.memwb_reg_write", memwb_reg_write, 0);
    check("rst_wait.dmem_req", dmem_req, 0);
    dmem_ack = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
